// File: rtl/div_unit_pkg.sv
// Shared constants, state encoding and operand helpers for the iterative DIV/DIVU unit.
package div_unit_pkg;

  localparam int   DATA_BUS_W = 32;
  localparam int   DIV_CYCLES = 32;
  localparam logic RST_ENABLE = 1'b0;

  typedef logic [DATA_BUS_W-1:0] data_bus_t;

  localparam data_bus_t ZERO_WORD = '0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

  // Two's-complement magnitude; 0x80000000 wraps to itself, which the
  // restoring loop then treats as the unsigned value 2^31.
  function automatic data_bus_t mag(input data_bus_t x, input logic en);
    return (en && x[DATA_BUS_W-1]) ? (ZERO_WORD - x) : x;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring DIV/DIVU: 33 cycles from accept to done (1 for divide-by-zero).
// Holds stall_req while accepting/running; cancel aborts to IDLE and suppresses done.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              cancel,
  output logic              stall_req,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int                CNT_W    = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  div_state_t        r_state;
  logic [DATA_W-1:0] r_dvd;
  logic [DATA_W-1:0] r_dsr;
  logic [DATA_W-1:0] r_rem;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dvd_sign;
  logic              r_q_sign;
  logic              r_done;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_remo;

  logic [DATA_W-1:0] w_partial;
  logic              w_ge;
  logic [DATA_W-1:0] w_rem_nx;
  logic [DATA_W-1:0] w_dvd_nx;
  logic              w_accept;

  // Before the last iteration the running remainder is below 2^31, so a
  // 32-bit partial never loses its top bit.
  always_comb begin
    w_partial = {r_rem[DATA_W-2:0], r_dvd[DATA_W-1]};
    w_ge      = (w_partial >= r_dsr);
    w_rem_nx  = w_ge ? (w_partial - r_dsr) : w_partial;
    w_dvd_nx  = {r_dvd[DATA_W-2:0], w_ge};
  end

  assign w_accept  = (rst != RST_ENABLE) && (r_state == DIV_IDLE) && start && !cancel;
  assign stall_req = w_accept || (r_state == DIV_RUN);
  assign busy      = (r_state != DIV_IDLE);
  assign done      = r_done && !cancel;
  assign quotient  = r_quot;
  assign remainder = r_remo;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state    <= DIV_IDLE;
      r_dvd      <= '0;
      r_dsr      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_dvd_sign <= 1'b0;
      r_q_sign   <= 1'b0;
      r_done     <= 1'b0;
      r_quot     <= '0;
      r_remo     <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          r_done <= 1'b0;
          if (start && !cancel) begin
            r_dvd      <= mag(dividend, signed_div);
            r_dsr      <= mag(divisor, signed_div);
            r_rem      <= '0;
            r_cnt      <= '0;
            r_dvd_sign <= signed_div && dividend[DATA_W-1];
            r_q_sign   <= signed_div && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            if (divisor == '0) begin
              r_state <= DIV_DONE;
              r_done  <= 1'b1;
              r_quot  <= '0;
              r_remo  <= '0;
            end else begin
              r_state <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          if (cancel) begin
            r_state <= DIV_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_dvd <= w_dvd_nx;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_state <= DIV_DONE;
              r_done  <= 1'b1;
              r_quot  <= r_q_sign   ? (ZERO_WORD - w_dvd_nx) : w_dvd_nx;
              r_remo  <= r_dvd_sign ? (ZERO_WORD - w_rem_nx) : w_rem_nx;
            end
          end
        end
        DIV_DONE: begin
          r_state <= DIV_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= DIV_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide-by-zero, cancel, reset, back-to-back.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_assert = 0;
  int n_fail   = 0;

  div_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .cancel     (cancel),
    .stall_req  (stall_req),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at edge+1 of an IDLE cycle; drives the request and checks the accept cycle.
  task automatic accept(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    start      = 1'b1;
    signed_div = sgn;
    dividend   = a;
    divisor    = b;
    #1;
    chk({tag, "_stall_accept"}, 32'(stall_req), 32'd1);
    chk({tag, "_busy_accept"},  32'(busy),      32'd0);
  endtask

  // Waits (bounded) for done; checks latency, stall cycles and results.
  task automatic wait_done(input string tag, input int exp_k, input logic [31:0] exp_q,
                           input logic [31:0] exp_r, input logic drop_start);
    int k;
    int stalls;
    k      = 0;
    stalls = 1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1 && drop_start) start = 1'b0;
      #1;
      if (done) begin
        k = i;
        break;
      end
      if (stall_req) stalls++;
    end
    chk({tag, "_latency"},    32'(k),         32'(exp_k));
    chk({tag, "_stall_cnt"},  32'(stalls),    32'(exp_k));
    chk({tag, "_stall_done"}, 32'(stall_req), 32'd0);
    chk({tag, "_quotient"},   quotient,       exp_q);
    chk({tag, "_remainder"},  remainder,      exp_r);
  endtask

  initial begin
    int hits;
    rst        = 1'b0;
    start      = 1'b1;
    signed_div = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    cancel     = 1'b0;

    // Reset state, with start asserted to show it is ignored.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_quot",  quotient,       32'd0);
    chk("rst_rem",   remainder,      32'd0);
    start = 1'b0;
    rst   = 1'b1;

    @(posedge clk); #1; accept("u100_7", 1'b0, 32'd100, 32'd7);
    wait_done("u100_7", 33, 32'd14, 32'd2, 1'b1);
    @(posedge clk); #2;
    chk("u100_7_done_pulse", 32'(done), 32'd0);
    chk("u100_7_idle",       32'(busy), 32'd0);

    @(posedge clk); #1; accept("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done("s_m7_2", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);

    @(posedge clk); #1; accept("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done("s_7_m2", 33, 32'hFFFF_FFFD, 32'd1, 1'b1);

    @(posedge clk); #1; accept("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("s_min_m1", 33, 32'h8000_0000, 32'd0, 1'b1);

    @(posedge clk); #1; accept("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done("u_max_1", 33, 32'hFFFF_FFFF, 32'd0, 1'b1);

    @(posedge clk); #1; accept("u_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_done("u_fff9_2", 33, 32'h7FFF_FFFC, 32'd1, 1'b1);

    @(posedge clk); #1; accept("div0", 1'b0, 32'h0000_1234, 32'd0);
    wait_done("div0", 1, 32'd0, 32'd0, 1'b1);

    // Cancel in the 10th RUN cycle.
    @(posedge clk); #1; accept("cancel", 1'b0, 32'd100, 32'd7);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
    end
    cancel = 1'b1;
    #1;
    chk("cancel_run_stall", 32'(stall_req), 32'd1);
    chk("cancel_run_done",  32'(done),      32'd0);
    @(posedge clk); #1;
    cancel = 1'b0;
    #1;
    chk("cancel_idle_busy",  32'(busy),      32'd0);
    chk("cancel_idle_stall", 32'(stall_req), 32'd0);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (done) hits++;
    end
    chk("cancel_no_done", 32'(hits), 32'd0);

    @(posedge clk); #1; accept("u20_3", 1'b0, 32'd20, 32'd3);
    wait_done("u20_3", 33, 32'd6, 32'd2, 1'b1);

    // Reset during RUN, start held high through reset.
    @(posedge clk); #1; accept("rstrun", 1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("rstrun_busy",  32'(busy),      32'd0);
    chk("rstrun_stall", 32'(stall_req), 32'd0);
    chk("rstrun_done",  32'(done),      32'd0);
    chk("rstrun_quot",  quotient,       32'd0);
    chk("rstrun_rem",   remainder,      32'd0);
    start = 1'b0;
    rst   = 1'b1;

    // Back-to-back: start held through DONE, new operands presented in DONE.
    @(posedge clk); #1; accept("b2b_a", 1'b0, 32'd100, 32'd7);
    wait_done("b2b_a", 33, 32'd14, 32'd2, 1'b0);
    dividend = 32'd20;
    divisor  = 32'd3;
    @(posedge clk); #2;
    chk("b2b_idle_busy",   32'(busy),      32'd0);
    chk("b2b_accept_stall", 32'(stall_req), 32'd1);
    wait_done("b2b_b", 33, 32'd6, 32'd2, 1'b1);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle iterative divider and sequencer for DIV/DIVU; sits beside the EX stage and produces the HI/LO write data for those instructions. EX asserts `start` with latched operands. The unit raises `stall_req` to pipeline control while it runs. It pulses `done` with quotient (for LO) and remainder (for HI) so EX can drive its HI/LO write port. Restoring division, one quotient bit per cycle.

## Interface
- `DATA_W`: default 32. Operand and result width; fixed at 32 for this core.
- `clk`: in, 1. Rising-edge clock.
- `rst`: in, 1. Synchronous, active-low reset; asserted when `rst` == `RST_ENABLE` (1'b0).
- `start`: in, 1. EX requests a divide; held stable by the pipeline while `stall_req` is high.
- `signed_div`: in, 1. 1 = DIV, 0 = DIVU; sampled with `start`.
- `dividend`: in, 32. Sampled on acceptance.
- `divisor`: in, 32. Sampled on acceptance.
- `cancel`: in, 1. Flush (exception or annulled slot); aborts any operation.
- `stall_req`: out, 1. To pipeline control; freeze IF..EX.
- `busy`: out, 1. State is not IDLE.
- `done`: out, 1. One-cycle pulse; `quotient`/`remainder` valid.
- `quotient`: out, 32. LO write data.
- `remainder`: out, 32. HI write data.

## Operation
- Reset: state IDLE. `done`, `busy`, `quotient`, `remainder` and the counter are all 0. `stall_req` is 0 because `start` is ignored while in reset.
- IDLE:
  - Accept when `start` && !`cancel`.
  - On accept, latch |dividend|, |divisor|, `signed_div`, the dividend sign and the quotient sign (dividend[31] ^ divisor[31], signed only). Magnitudes are taken only when `signed_div` = 1.
  - If divisor == 0, go to DONE. Otherwise go to RUN with the counter at 0.
- RUN, per cycle:
  - Compute partial = {rem[30:0], dvd[31]}.
  - If partial >= divisor, set rem = partial − divisor and shift in a 1. Otherwise set rem = partial and shift in a 0.
  - Shift dvd left; increment the counter.
  - After 32 iterations (counter == 31 at the edge), go to DONE.
- DONE, a single cycle:
  - `done` = 1.
  - quotient = negated magnitude quotient if the quotient sign is set, else the magnitude.
  - remainder = negated if the dividend sign is set, else the magnitude.
  - Divide-by-zero result: quotient = 0, remainder = 0.
  - Always go to IDLE next.
- `stall_req` = (IDLE && `start` && !`cancel`) || RUN. It is low in DONE, so the pipeline advances on the DONE edge, and any `start` seen in the following IDLE belongs to the next instruction.
- `cancel` in RUN or DONE: next state IDLE; `done` is forced low that cycle; the outputs hold their last value.
- `cancel` in IDLE: `start` is ignored.
- Width rules:
  - All arithmetic is modulo 2^32.
  - The signed 0x80000000 / 0xFFFFFFFF case yields quotient 0x80000000 and remainder 0 (wraps; no trap).
- Outputs `quotient`/`remainder` are registered and meaningful only when `done` = 1. EX must ignore them otherwise.

## Timing
- Accept edge T0.
- Nonzero divisor: RUN for cycles T0+1..T0+32; `done` is high in cycle T0+33. Latency is 33 cycles from the accept edge.
- Zero divisor: `done` is high in cycle T0+1.
- `stall_req` is high combinationally in the accept cycle and in all RUN cycles; it is low in DONE.
- Back-to-back divides: the earliest next accept is the cycle after DONE.
- Reset mid-operation takes priority over everything: next cycle is IDLE with all outputs 0 and no `done`.

## Structure
- Shared define file:
  - State encodings `DIV_IDLE`, `DIV_RUN`, `DIV_DONE` (2-bit).
  - `DIV_CYCLES` = 32.
  - Existing `RST_ENABLE`, `ZERO_WORD`, `DATA_BUS`.
- Single module; no sub-module. The per-iteration subtract/compare is an inline combinational term.
- The EX-side HI/LO mux consumes `done` and is outside this block.

## Test plan
- Unsigned 100 / 7: `stall_req` high for 33 cycles; `done` at T0+33 with quotient 14 and remainder 2.
- Signed −7 / 2 (0xFFFFFFF9 / 2): quotient 0xFFFFFFFD and remainder 0xFFFFFFFF. Also 7 / −2 gives quotient 0xFFFFFFFD and remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
- Divisor 0 with dividend 0x1234: `done` at T0+1 with 0/0; `stall_req` high only in the accept cycle.
- `cancel` at the 10th RUN cycle: IDLE next cycle, no `done` pulse. A new `start` 20/3 then completes normally with quotient 6 and remainder 2.
- `rst` low during RUN: next cycle all outputs are 0 and state is IDLE. Back-to-back: `start` held through DONE is accepted in the following IDLE cycle and yields a second correct result.
